regfile_write_arbiter: RTL and testbench

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

---
 rtl/regfile_write_arbiter.sv | 108 ++++++++++
 tb/tb_regfile_write_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter: round-robin grant of three write
// requesters into a single registered write stage with stall back-pressure.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   reqValid[3]    per-requester write request (0=ALU, 1=MEM, 2=SYS)
//   reqSel[12]     per-requester destination index, bits [4i+3:4i]
//   reqData        per-requester write data, DATA_W bits each
//   reqReady[3]    one-hot grant (combinational)
//   stall          register file cannot accept a write this cycle
//   wrEn/wrSel/wrData  held write in the output stage
//   wr[16]         one-hot register write strobe
//   conflictCount  saturating count of contended cycles
module regfile_write_arbiter #(
  parameter int DATA_W = 8,
  parameter int NREQ   = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        reqValid,
  input  logic [4*NREQ-1:0]      reqSel,
  input  logic [DATA_W*NREQ-1:0] reqData,
  output logic [NREQ-1:0]        reqReady,
  input  logic                   stall,
  output logic                   wrEn,
  output logic [3:0]             wrSel,
  output logic [DATA_W-1:0]      wrData,
  output logic [15:0]            wr,
  output logic [7:0]             conflictCount
);

  logic [1:0]        lastGrant;
  logic [2:0]        grant;
  logic [2:0]        start;
  logic [2:0]        idx;
  logic              found;
  logic              xfer;
  logic              multi;
  logic [1:0]        gidx;
  logic [3:0]        gsel;
  logic [DATA_W-1:0] gdata;

  // Rotating priority: search starts one past the last granted requester.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    start = (lastGrant == 2'd2) ? 3'd0 : {1'b0, lastGrant} + 3'd1;
    if (rst_n && !stall) begin
      for (int k = 0; k < 3; k++) begin
        idx = start + k[2:0];
        if (idx >= 3'd3) idx = idx - 3'd3;
        if (!found && reqValid[idx[1:0]]) begin
          grant[idx[1:0]] = 1'b1;
          found = 1'b1;
        end
      end
    end
  end

  assign reqReady = grant;
  assign xfer     = |(reqValid & grant);

  always_comb begin
    gidx  = 2'd0;
    gsel  = reqSel[3:0];
    gdata = reqData[DATA_W-1:0];
    unique case (1'b1)
      grant[1]: begin
        gidx  = 2'd1;
        gsel  = reqSel[7:4];
        gdata = reqData[2*DATA_W-1:DATA_W];
      end
      grant[2]: begin
        gidx  = 2'd2;
        gsel  = reqSel[11:8];
        gdata = reqData[3*DATA_W-1:2*DATA_W];
      end
      default: ;
    endcase
  end

  assign multi = (reqValid[0] & reqValid[1]) |
                 (reqValid[0] & reqValid[2]) |
                 (reqValid[1] & reqValid[2]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrEn          <= 1'b0;
      wrSel         <= '0;
      wrData        <= '0;
      conflictCount <= '0;
      lastGrant     <= 2'd2;
    end else if (!stall) begin
      wrEn <= xfer;
      if (xfer) begin
        wrSel     <= gsel;
        wrData    <= gdata;
        lastGrant <= gidx;
      end
      if (multi && conflictCount != 8'hFF)
        conflictCount <= conflictCount + 8'd1;
    end
  end

  assign wr = wrEn ? (16'h0001 << wrSel) : 16'h0000;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed self-checking bench for regfile_write_arbiter.
// Inputs change 1 time unit after the rising edge; checks follow settling.
module tb_regfile_write_arbiter;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [2:0]    reqValid;
  logic [11:0]   reqSel;
  logic [23:0]   reqData;
  logic [2:0]    reqReady;
  logic          stall;
  logic          wrEn;
  logic [3:0]    wrSel;
  logic [DW-1:0] wrData;
  logic [15:0]   wr;
  logic [7:0]    conflictCount;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  regfile_write_arbiter #(.DATA_W(DW), .NREQ(3)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .reqValid(reqValid),
    .reqSel(reqSel),
    .reqData(reqData),
    .reqReady(reqReady),
    .stall(stall),
    .wrEn(wrEn),
    .wrSel(wrSel),
    .wrData(wrData),
    .wr(wr),
    .conflictCount(conflictCount)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [3:0] s,
                         input logic [7:0] d);
    reqSel[4*i +: 4] = s;
    reqData[8*i +: 8] = d;
  endtask

  task automatic chk_out(input string tag, input logic e,
                         input logic [3:0] s, input logic [7:0] d,
                         input logic [15:0] w);
    chk({tag, "_en"}, {31'd0, wrEn}, {31'd0, e});
    chk({tag, "_sel"}, {28'd0, wrSel}, {28'd0, s});
    chk({tag, "_data"}, {24'd0, wrData}, {24'd0, d});
    chk({tag, "_wr"}, {16'd0, wr}, {16'd0, w});
  endtask

  logic [2:0] exp_g [6];
  logic [7:0] exp_d [6];

  initial begin
    rst_n = 1'b0;
    stall = 1'b0;
    reqValid = 3'b111;
    reqSel = '0;
    reqData = '0;
    #3;
    chk_out("reset", 1'b0, 4'd0, 8'h00, 16'h0000);
    chk("reset_cc", {24'd0, conflictCount}, 32'd0);
    chk("reset_ready", {29'd0, reqReady}, 32'd0);
    tick();
    tick();

    // Three-way contention right after reset: 0,1,2,0,1,2
    rst_n = 1'b1;
    set_req(0, 4'd1, 8'h10);
    set_req(1, 4'd2, 8'h20);
    set_req(2, 4'd3, 8'h30);
    exp_g = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    exp_d = '{8'h10, 8'h20, 8'h30, 8'h10, 8'h20, 8'h30};
    for (int c = 0; c < 6; c++) begin
      #1;
      chk($sformatf("rr_ready%0d", c), {29'd0, reqReady}, {29'd0, exp_g[c]});
      tick();
      chk($sformatf("rr_en%0d", c), {31'd0, wrEn}, 32'd1);
      chk($sformatf("rr_data%0d", c), {24'd0, wrData}, {24'd0, exp_d[c]});
      chk($sformatf("rr_cc%0d", c), {24'd0, conflictCount}, c + 1);
    end
    reqValid = 3'b000;
    #1;
    chk("idle_ready", {29'd0, reqReady}, 32'd0);
    tick();
    chk("idle_en", {31'd0, wrEn}, 32'd0);
    chk("idle_wr", {16'd0, wr}, 32'd0);

    // Requester 1 alone: sel 5, data A7
    reqValid = 3'b010;
    set_req(1, 4'd5, 8'hA7);
    #1;
    chk("r1_ready", {29'd0, reqReady}, 32'b010);
    tick();
    chk_out("r1", 1'b1, 4'd5, 8'hA7, 16'h0020);
    chk("r1_cc", {24'd0, conflictCount}, 32'd6);
    reqValid = 3'b000;
    tick();

    // Held write to sel 15 frozen by a 3-cycle stall
    reqValid = 3'b100;
    set_req(2, 4'd15, 8'h5A);
    #1;
    chk("s_ready", {29'd0, reqReady}, 32'b100);
    tick();
    chk_out("s_load", 1'b1, 4'd15, 8'h5A, 16'h8000);
    stall = 1'b1;
    reqValid = 3'b011;
    set_req(0, 4'd4, 8'h44);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("st_ready%0d", c), {29'd0, reqReady}, 32'd0);
      tick();
      chk_out($sformatf("st_hold%0d", c), 1'b1, 4'd15, 8'h5A, 16'h8000);
      chk($sformatf("st_cc%0d", c), {24'd0, conflictCount}, 32'd6);
    end
    stall = 1'b0;
    #1;
    chk("unstall_ready", {29'd0, reqReady}, 32'b001);
    tick();
    chk_out("unstall", 1'b1, 4'd4, 8'h44, 16'h0010);
    chk("unstall_cc", {24'd0, conflictCount}, 32'd7);

    // Same destination from 0 and 2, served in grant order
    reqValid = 3'b100;
    set_req(2, 4'd7, 8'h77);
    #1;
    chk("pre_ready", {29'd0, reqReady}, 32'b100);
    tick();
    chk_out("pre", 1'b1, 4'd7, 8'h77, 16'h0080);
    reqValid = 3'b101;
    set_req(0, 4'd3, 8'h11);
    set_req(2, 4'd3, 8'h22);
    #1;
    chk("same_ready0", {29'd0, reqReady}, 32'b001);
    tick();
    chk_out("same0", 1'b1, 4'd3, 8'h11, 16'h0008);
    chk("same_cc", {24'd0, conflictCount}, 32'd8);
    reqValid = 3'b100;
    #1;
    chk("same_ready1", {29'd0, reqReady}, 32'b100);
    tick();
    chk_out("same1", 1'b1, 4'd3, 8'h22, 16'h0008);
    reqValid = 3'b000;
    tick();
    chk("same_idle", {31'd0, wrEn}, 32'd0);

    // Asynchronous reset in the middle of a burst
    reqValid = 3'b111;
    set_req(0, 4'd0, 8'hC0);
    set_req(1, 4'd9, 8'hC1);
    set_req(2, 4'd12, 8'hC2);
    tick();
    chk_out("burst", 1'b1, 4'd0, 8'hC0, 16'h0001);
    tick();
    chk("burst_en", {31'd0, wrEn}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk_out("async_rst", 1'b0, 4'd0, 8'h00, 16'h0000);
    chk("async_ready", {29'd0, reqReady}, 32'd0);
    chk("async_cc", {24'd0, conflictCount}, 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", {29'd0, reqReady}, 32'b001);
    tick();
    chk_out("post_rst", 1'b1, 4'd0, 8'hC0, 16'h0001);

    // Saturation of the conflict counter
    for (int c = 0; c < 300; c++) tick();
    chk("sat_cc", {24'd0, conflictCount}, 32'hFF);
    for (int c = 0; c < 5; c++) tick();
    chk("sat_hold", {24'd0, conflictCount}, 32'hFF);
    chk("sat_en", {31'd0, wrEn}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
